// File: rtl/lru_pkg.sv
// Shared definitions for the age-matrix LRU tracker.
// The optional lock feature in the tracker is enabled with LRU_LOCK_EN.
package lru_pkg;

  localparam int LRU_MAX_WAYS = 32;

  typedef enum logic [1:0] {LRU_TOUCH, LRU_ALLOC, LRU_INVAL} lru_evt_e;

  // Flat position of age bit "way i older than way j" (i > j) in the
  // packed lower-triangular matrix.
  function automatic int tri_idx(input int i, input int j);
    return (i * (i - 1)) / 2 + j;
  endfunction

endpackage

// File: rtl/lru_victim_sel.sv
// Combinational victim picker: lowest eligible invalid way first, otherwise
// the eligible way older than every other eligible way. Locked ways are
// never eligible (lock is tied low when LRU_LOCK_EN is not defined).
import lru_pkg::*;

module lru_victim_sel #(
  parameter  int WAYS  = 8,
  localparam int IDX_W = $clog2(WAYS),
  localparam int NB    = WAYS * (WAYS - 1) / 2
) (
  input  logic [NB-1:0]    older,
  input  logic [WAYS-1:0]  valid,
  input  logic [WAYS-1:0]  lock,
  output logic [WAYS-1:0]  victim_oh,
  output logic [IDX_W-1:0] victim_idx,
  output logic             victim_ok
);

  logic             age [WAYS][WAYS];
  logic [WAYS-1:0]  elig, cand, inv_oh, old_oh;

  // Expand the triangle into a full relation: age[i][j] = way i older than j.
  for (genvar gi = 0; gi < WAYS; gi++) begin : g_row
    for (genvar gj = 0; gj < WAYS; gj++) begin : g_col
      if (gi > gj) begin : g_lo
        assign age[gi][gj] = older[tri_idx(gi, gj)];
      end else if (gi < gj) begin : g_hi
        assign age[gi][gj] = ~older[tri_idx(gj, gi)];
      end else begin : g_diag
        assign age[gi][gj] = 1'b1;
      end
    end
  end

  assign elig = ~lock;
  assign cand = ~valid & elig;

  // Priority-encode the lowest eligible invalid way.
  always_comb begin
    logic found;
    found  = 1'b0;
    inv_oh = '0;
    for (int i = 0; i < WAYS; i++) begin
      if (cand[i] && !found) begin
        inv_oh[i] = 1'b1;
        found     = 1'b1;
      end
    end
  end

  // Oldest eligible way: older than every other eligible way.
  always_comb begin
    old_oh = '0;
    for (int i = 0; i < WAYS; i++) begin
      old_oh[i] = elig[i];
      for (int j = 0; j < WAYS; j++) begin
        if (j != i && elig[j] && !age[i][j]) old_oh[i] = 1'b0;
      end
    end
  end

  assign victim_oh = (|cand) ? inv_oh : old_oh;
  assign victim_ok = |elig;

  // One-hot to index.
  always_comb begin
    victim_idx = '0;
    for (int i = 0; i < WAYS; i++) begin
      if (victim_oh[i]) victim_idx = victim_idx | IDX_W'(i);
    end
  end

endmodule

// File: rtl/lru_age_matrix.sv
// True-LRU tracker: triangular age matrix plus valid mask, with touch,
// allocate and invalidate events applied in order inval, alloc, touch.
// Define LRU_LOCK_EN to add the lock_mask port that excludes ways from
// victim selection.
import lru_pkg::*;

module lru_age_matrix #(
  parameter  int WAYS  = 8,
  localparam int IDX_W = $clog2(WAYS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             touch_en,
  input  logic [IDX_W-1:0] touch_idx,
  input  logic             alloc_en,
  input  logic             inval_en,
  input  logic [IDX_W-1:0] inval_idx,
`ifdef LRU_LOCK_EN
  input  logic [WAYS-1:0]  lock_mask,
`endif
  output logic [IDX_W-1:0] victim_idx,
  output logic [WAYS-1:0]  victim_oh,
  output logic             victim_ok,
  output logic [WAYS-1:0]  valid_mask,
  output logic             full
);

  localparam int NB = WAYS * (WAYS - 1) / 2;

  logic [NB-1:0]   older_q, older_d;
  logic [WAYS-1:0] valid_q, valid_d, lock;
  logic            a_go, t_go, i_go;

`ifdef LRU_LOCK_EN
  assign lock = lock_mask;
`else
  assign lock = '0;
`endif

  lru_victim_sel #(.WAYS(WAYS)) u_sel (
    .older      (older_q),
    .valid      (valid_q),
    .lock       (lock),
    .victim_oh  (victim_oh),
    .victim_idx (victim_idx),
    .victim_ok  (victim_ok)
  );

  // Out-of-range indices (non-power-of-2 WAYS) drop the event.
  assign a_go = alloc_en & victim_ok;
  assign t_go = touch_en & ({1'b0, touch_idx} < (IDX_W + 1)'(WAYS));
  assign i_go = inval_en & ({1'b0, inval_idx} < (IDX_W + 1)'(WAYS));

  // Age bit (i,j): alloc promote first, then touch promote on top, so a
  // touched way always ends MRU. Same-way alloc+touch collapses to one.
  for (genvar gi = 1; gi < WAYS; gi++) begin : g_ai
    for (genvar gj = 0; gj < gi; gj++) begin : g_aj
      localparam int B = tri_idx(gi, gj);
      logic after_a;
      assign after_a = (a_go && victim_idx == IDX_W'(gi)) ? 1'b0 :
                       (a_go && victim_idx == IDX_W'(gj)) ? 1'b1 : older_q[B];
      assign older_d[B] = (t_go && touch_idx == IDX_W'(gi)) ? 1'b0 :
                          (t_go && touch_idx == IDX_W'(gj)) ? 1'b1 : after_a;
    end
  end

  // Valid: invalidate, then allocate (alloc wins on the same way).
  for (genvar g = 0; g < WAYS; g++) begin : g_v
    assign valid_d[g] = (a_go && victim_oh[g]) ? 1'b1 :
                        (i_go && inval_idx == IDX_W'(g)) ? 1'b0 : valid_q[g];
  end

  // State flops; reset orders way WAYS-1 oldest down to way 0 newest.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      older_q <= '1;
      valid_q <= '0;
    end else begin
      older_q <= older_d;
      valid_q <= valid_d;
    end
  end

  assign valid_mask = valid_q;
  assign full       = &valid_q;

endmodule

// File: doc/lru_age_matrix.md
Name: lru_age_matrix

Overview:
- Parametrised true-LRU replacement tracker for the victim cache and other fully-associative structures.
- Holds a triangular age matrix over WAYS entries plus a per-way valid mask.
- Accepts hit-touch, allocate and invalidate events, and always presents the current victim.
- Successor to the fixed 8-entry tracker. Adds: arbitrary way count, index-encoded interfaces, invalid-first victim choice, invalidation, and defined simultaneous-event ordering.

Parameters:
- WAYS, 8, number of tracked entries. Legal range 2..32.
- IDX_W, $clog2(WAYS), width of way indices. Derived; do not override.

Ports:
- clk  in  1  clock, rising-edge.
- reset  in  1  asynchronous, active-high reset.
- touch_en  in  1  hit update: mark touch_idx most-recently-used (MRU).
- touch_idx  in  IDX_W  way hit.
- alloc_en  in  1  allocate: victim_idx becomes valid and MRU at this edge.
- inval_en  in  1  invalidate inval_idx.
- inval_idx  in  IDX_W  way to invalidate.
- lock_mask  in  WAYS  per-way lock. Only present with LRU_LOCK_EN.
- victim_idx  out  IDX_W  way the next allocate will fill.
- victim_oh  out  WAYS  one-hot of victim_idx.
- victim_ok  out  1  a victim exists. Always 1 unless LRU_LOCK_EN blocks every way.
- valid_mask  out  WAYS  per-way valid.
- full  out  1  &valid_mask.

Behaviour:
- State:
  - older[i][j] for i>j, WAYS*(WAYS-1)/2 flops. 1 means way i is older than way j; for j>i the relation is the inverse bit.
  - valid[WAYS] flops.
- Promote way k to MRU:
  - for every j≠k, set "j older than k" true and "k older than j" false;
  - bits not involving k are unchanged.
- Reset (async, immediate): valid = 0; all older bits = 1, giving order way WAYS-1 oldest … way 0 newest.
- Reset values of outputs: victim_idx = 0 (lowest invalid way), victim_oh = 1, victim_ok = 1, full = 0.
- Victim selection (combinational from registered state, zero latency):
  - if any way is invalid, choose the lowest-index invalid way;
  - otherwise choose the unique way older than all others.
  - Exactly one bit of victim_oh is set whenever victim_ok = 1.
- Updates take effect at the rising clk edge and are visible next cycle.
- alloc_en:
  - valid[victim_idx] <= 1;
  - promote victim_idx;
  - ignored when victim_ok = 0.
- touch_en:
  - promote touch_idx;
  - touching an invalid way updates age but not valid.
- inval_en:
  - valid[inval_idx] <= 0;
  - age bits unchanged;
  - the way becomes victim on the next cycle if it is the lowest invalid way.
- Ordering within one cycle: inval, then alloc, then touch.
  - Touch and alloc of different ways: the touch way ends MRU and the alloc way second-MRU.
  - Touch and alloc of the same way: a single promote.
  - Inval and alloc of the same way: alloc wins, way valid.
  - Inval and touch of the same way: way invalid and MRU.
- Out-of-range index (≥ WAYS, non-power-of-2 WAYS): the event is ignored.
- Reset asserted mid-operation overrides all events in that cycle.

Optional Feature:
- Macro: LRU_LOCK_EN.
- With it defined:
  - lock_mask port exists;
  - locked ways are excluded from victim selection (invalid-first, then oldest unlocked way by age relative to unlocked ways only);
  - victim_ok = 0 when all ways are locked;
  - touches and invalidates of locked ways still apply.
- Without it: no lock_mask port; victim_ok is tied to 1.

Decomposition:
- Package lru_pkg:
  - LRU_MAX_WAYS = 32;
  - typedef lru_evt_e {LRU_TOUCH, LRU_ALLOC, LRU_INVAL} for bench and monitors;
  - function tri_idx(i, j) mapping a pair to a flat matrix bit.
- Sub-module lru_victim_sel: combinational. Inputs are the older vector, valid mask and optional lock mask; outputs are victim_oh, victim_idx and victim_ok. It contains the priority encoder and the oldest-way AND-reduction.
- Top holds the flops and the promote/valid update logic.

Test Plan:
- Reset, WAYS=8 → valid_mask=0x00, victim_idx=0, full=0. Eight consecutive alloc_en → victim_idx 0,1,…,7 in turn; full=1 and victim_idx=0 afterwards (way 0 oldest).
- Full set, touch 0,1,2 in consecutive cycles → victim_idx=3. Then alloc_en → way 3 MRU, victim_idx=4.
- Full set, inval_idx=5 → next cycle victim_idx=5, full=0, valid_mask=0xDF. Alloc → valid_mask=0xFF, way 5 MRU.
- Same cycle: alloc_en (victim 4) with touch_idx=6 → way 6 MRU, way 4 second. Then touch the other six ways → victim_idx=4.
- Reset asserted asynchronously between edges during alloc → outputs return to reset values immediately, with no update at the following edge. Repeat with WAYS=5 and touch_idx=7 → ignored.
- LRU_LOCK_EN, full set, lock_mask=0x01 with way 0 oldest → victim_idx = next-oldest way. lock_mask=0xFF → victim_ok=0, and alloc_en leaves state unchanged.
